adc_temp_conv: RTL and testbench

Periodic ADC-to-temperature conversion stage, directly upstream of the peripheral display/PWM logic. Samples the 12-bit `adc_value` bus at a fixed interval and optionally averages samples. Scales the result to whole degrees Celsius with a multi-cycle sequential divider. Presents the temperature with a one-cycle valid strobe for the display and PWM consumers.

---
 rtl/adc_temp_pkg.sv | 17 +
 rtl/seq_divider.sv | 60 ++++++
 rtl/adc_temp_conv.sv | 132 +++++++++++++
 tb/tb_adc_temp_conv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_temp_pkg.sv
// Shared types and constants for the ADC-to-temperature conversion stage.
package adc_temp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    DIV,
    DONE
  } state_t;

  localparam int unsigned TEMP_DIVISOR = 40;
  localparam int unsigned MV_W         = 14;
  localparam int unsigned TEMP_W       = 8;
  localparam int unsigned DIV_STEPS    = 14;
  localparam int unsigned DVSR_W       = 6;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The dividend register shifts left and receives quotient bits, so after the
// last step it holds the quotient. `quotient` is combinational and valid in
// the cycle `done` is high (it already includes the final bit).
module seq_divider
  import adc_temp_pkg::*;
#(
  parameter int unsigned DVD_W  = MV_W,
  parameter int unsigned DVSR_W = adc_temp_pkg::DVSR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DVD_W-1:0]  dividend,
  input  logic [DVSR_W-1:0] divisor,
  output logic [DVD_W-1:0]  quotient,
  output logic              done
);

  localparam int unsigned STEP_W = $clog2(DVD_W);

  logic [DVD_W-1:0]  quo_q;
  logic [DVSR_W-1:0] rem_q;
  logic [STEP_W-1:0] step_q;
  logic              run_q;

  logic [DVSR_W:0]   trial;
  logic              fits;
  logic [DVSR_W-1:0] rem_next;

  // One restoring step: bring down the next dividend bit and try a subtract.
  always_comb begin
    trial    = {rem_q, quo_q[DVD_W-1]};
    fits     = (trial >= {1'b0, divisor});
    rem_next = fits ? DVSR_W'(trial - {1'b0, divisor}) : trial[DVSR_W-1:0];
    quotient = {quo_q[DVD_W-2:0], fits};
    done     = run_q && (step_q == STEP_W'(DVD_W - 1));
  end

  // Iteration state: load on start, shift one bit per cycle while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      quo_q  <= quotient;
      rem_q  <= rem_next;
      step_q <= step_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_temp_conv.sv
// Periodic ADC sampling, optional averaging, scaling to millivolts and
// division to whole degrees Celsius with a one-cycle valid strobe.
// Define ADC_TEMP_AVG_EN to average 2^AVG_LOG2 samples per conversion;
// otherwise every accepted sample starts a conversion.
module adc_temp_conv
  import adc_temp_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned ADC_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  adc_value,
  input  logic              hold,
  output logic [TEMP_W-1:0] temp_c,
  output logic              temp_valid,
  output logic              busy
);

  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              accept;
  logic              conv_start;
  logic [ADC_W-1:0]  avg_q;
  logic [MV_W-1:0]   mv;
  state_t            state, state_next;
  logic              div_start;
  logic              div_done;
  logic [MV_W-1:0]   div_quo;

  assign tick   = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
  assign accept = tick && !hold && (state == IDLE);
  assign mv     = MV_W'(avg_q) + MV_W'(avg_q >> 2);

  // Free-running sample interval counter, independent of hold and busy.
  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef ADC_TEMP_AVG_EN
  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic             last_sample;

  assign acc_sum     = acc_q + ACC_W'(adc_value);
  assign last_sample = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
  assign conv_start  = accept && last_sample;

  // Accumulate accepted samples; the final one of a group produces the mean.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
    end else if (accept) begin
      if (last_sample) begin
        acc_q <= '0;
        cnt_q <= '0;
        avg_q <= ADC_W'(acc_sum >> AVG_LOG2);
      end else begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  assign conv_start = accept;

  // Each accepted sample is converted directly.
  always_ff @(posedge clk) begin
    if (reset)       avg_q <= '0;
    else if (accept) avg_q <= adc_value;
  end
`endif

  seq_divider #(
    .DVD_W (MV_W),
    .DVSR_W(DVSR_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(mv),
    .divisor (DVSR_W'(TEMP_DIVISOR)),
    .quotient(div_quo),
    .done    (div_done)
  );

  // Conversion sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (conv_start) state_next = SCALE;
      SCALE: begin
        div_start  = 1'b1;
        state_next = DIV;
      end
      DIV:     if (div_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result is registered on entry to DONE so temp_c and the strobe line up
  // with the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      temp_c     <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= (state == DIV) && div_done;
      if ((state == DIV) && div_done) temp_c <= TEMP_W'(div_quo);
    end
  end

endmodule

// File: tb/tb_adc_temp_conv.sv
// Randomized bench for adc_temp_conv with a cycle-level reference model
// derived from sample timing and integer arithmetic.
module tb_adc_temp_conv;

  localparam int SD = 1000;
  localparam int AL = 2;
`ifdef ADC_TEMP_AVG_EN
  localparam int NAVG = 1 << AL;
`else
  localparam int NAVG = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [11:0] adc_value = '0;
  logic [7:0]  temp_c;
  logic        temp_valid;
  logic        busy;

  adc_temp_conv #(
    .SAMPLE_DIV(SD),
    .AVG_LOG2  (AL),
    .ADC_W     (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_value (adc_value),
    .hold      (hold),
    .temp_c    (temp_c),
    .temp_valid(temp_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model state (cycle index counts from the first cycle out of reset)
  int c = 0;
  bit armed = 0;
  int m_sum = 0;
  int m_n = 0;
  bit m_active = 0;
  int m_cap = 0;
  int m_pending = 0;
  int m_temp = 0;

  // Stimulus control
  int pat[4] = '{0, 0, 0, 0};
  int pat_idx = 0;
  bit rnd_mode = 0;
  int rst_at = -1;
  int valid_cnt = 0;

  // One clock: check outputs of the current cycle, drive this cycle's inputs,
  // then advance the model by what the coming edge will sample.
  task automatic step(input bit rst);
    bit ev, eb, idle, rst_eff;
    int avg, r;
    @(negedge clk);
    idle = 1;
    if (armed) begin
      ev = m_active && (c == m_cap + 16);
      eb = m_active && (c >= m_cap + 1) && (c <= m_cap + 16);
      if (ev) m_temp = m_pending;
      check("temp_valid", int'(temp_valid), int'(ev));
      check("busy", int'(busy), int'(eb));
      check("temp_c", int'(temp_c), m_temp);
      if (temp_valid) valid_cnt++;
      idle = !eb;
      if (ev) m_active = 0;
    end
    rst_eff = rst || (rnd_mode && c == rst_at);
    if (c % SD == SD / 2) begin
      if (rnd_mode) begin
        r = $urandom_range(0, 9);
        pat[pat_idx % 4] = (r == 0) ? 0 : (r == 1) ? 4095 : int'($urandom_range(0, 4095));
        hold = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 9) == 0) rst_at = c + SD / 2 - 1 + int'($urandom_range(1, 18));
      end
      adc_value = 12'(pat[pat_idx % 4]);
      pat_idx++;
    end
    reset = rst_eff;
    if (rst_eff) begin
      c = 0; armed = 1; m_sum = 0; m_n = 0; m_active = 0; m_temp = 0;
      pat_idx = 0; rst_at = -1;
    end else begin
      if ((c % SD == SD - 1) && !hold && idle) begin
        m_sum += int'(adc_value);
        m_n++;
        if (m_n == NAVG) begin
          avg       = m_sum / NAVG;
          m_pending = (avg + avg / 4) / 40;
          m_cap     = c;
          m_active  = 1;
          m_sum     = 0;
          m_n       = 0;
        end
      end
      c++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1);
  endtask

  initial begin
    int t0;
    bit seen;

    // Reset, then constant 819: first strobe latency and value
    pat = '{819, 819, 819, 819};
    do_reset(3);
    check("reset_temp_c", int'(temp_c), 0);
    check("reset_busy", int'(busy), 0);
    t0 = -1;
    for (int i = 0; i < 5 * SD; i++) begin
      step(1'b0);
      if (temp_valid) begin
        t0 = c - 1;
        break;
      end
    end
    check("first_valid_cycle", t0, NAVG * SD - 1 + 16);
    check("first_temp", int'(temp_c), 25);
    run(NAVG * SD);

    // Full scale, and strobe count per conversion period
    pat = '{4095, 4095, 4095, 4095};
    do_reset(2);
    valid_cnt = 0;
    run(NAVG * SD + 20);
    check("temp_max", int'(temp_c), 127);
    check("valid_count_1", valid_cnt, 1);
    valid_cnt = 0;
    run(2 * NAVG * SD);
    check("valid_count_2", valid_cnt, 2);

    // Zero input
    pat = '{0, 0, 0, 0};
    do_reset(2);
    run(NAVG * SD + 20);
    check("temp_zero", int'(temp_c), 0);

    // Averaging patterns
    pat = '{0, 0, 0, 4095};
    do_reset(2);
    run(NAVG * SD + 20);
`ifdef ADC_TEMP_AVG_EN
    check("avg_mixed", int'(temp_c), 31);
`else
    check("avg_mixed", int'(temp_c), 0);
`endif
    pat = '{800, 820, 840, 860};
    do_reset(2);
    run(NAVG * SD + 20);
    check("avg_ramp", int'(temp_c), 25);

    // Hold across five ticks with a partial group pending
    pat = '{820, 820, 820, 820};
    run(2 * SD);
    valid_cnt = 0;
    hold = 1'b1;
    run(5 * SD);
    hold = 1'b0;
    check("hold_no_valid", valid_cnt, 0);
    check("hold_temp", int'(temp_c), 25);
    run(NAVG * SD + 100);

    // Reset five cycles after SCALE
    pat = '{819, 819, 819, 819};
    seen = 0;
    for (int i = 0; i < 5 * SD; i++) begin
      step(1'b0);
      if (busy) begin
        seen = 1;
        break;
      end
    end
    check("mid_div_busy_seen", int'(seen), 1);
    run(4);
    step(1'b1);
    valid_cnt = 0;
    step(1'b0);
    check("mid_div_busy", int'(busy), 0);
    check("mid_div_temp", int'(temp_c), 0);
    run(30);
    check("mid_div_no_valid", valid_cnt, 0);
    run(NAVG * SD);

    // Randomized samples, holds and resets
    rnd_mode = 1;
    run(35000);
    rnd_mode = 0;
    hold = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
